// File: rtl/eeprom_pkg.sv
// rtl/eeprom_pkg.sv - shared state encoding and bus constants for the I2C EEPROM target
package eeprom_pkg;
    localparam logic [6:0] SLA7_DEFAULT = 7'h50;
    localparam int         ADDR16_W     = 16;
    localparam logic       I2C_ACK      = 1'b0;
    localparam logic       I2C_NACK     = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV,
        ST_ACK_DEV,
        ST_AH,
        ST_ACK_AH,
        ST_AL,
        ST_ACK_AL,
        ST_WDATA,
        ST_ACK_W,
        ST_RDATA,
        ST_RACK,
        ST_IGNORE
    } i2c_state_e;
endpackage

// File: rtl/i2c_bus_sync.sv
// rtl/i2c_bus_sync.sv - SCL/SDA synchronizers with registered SCL edge and START/STOP strobes
module i2c_bus_sync (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_bit,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);
    logic [1:0] scl_sync_q, scl_sync_d;
    logic [1:0] sda_sync_q, sda_sync_d;
    logic       scl_prev_q, scl_prev_d;
    logic       sda_prev_q, sda_prev_d;
    logic       sda_bit_q, sda_bit_d;
    logic       scl_rise_q, scl_rise_d;
    logic       scl_fall_q, scl_fall_d;
    logic       start_q, start_d;
    logic       stop_q, stop_d;

    // START/STOP need SCL high on both samples so a simultaneous SCL fall never looks like one
    always_comb begin
        scl_sync_d = {scl_sync_q[0], scl_in};
        sda_sync_d = {sda_sync_q[0], sda_in};
        scl_prev_d = scl_sync_q[1];
        sda_prev_d = sda_sync_q[1];
        sda_bit_d  = sda_sync_q[1];
        scl_rise_d = scl_sync_q[1] & ~scl_prev_q;
        scl_fall_d = ~scl_sync_q[1] & scl_prev_q;
        start_d    = scl_sync_q[1] & scl_prev_q & ~sda_sync_q[1] & sda_prev_q;
        stop_d     = scl_sync_q[1] & scl_prev_q & sda_sync_q[1] & ~sda_prev_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            sda_bit_q  <= 1'b1;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
            sda_bit_q  <= sda_bit_d;
            scl_rise_q <= scl_rise_d;
            scl_fall_q <= scl_fall_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
        end
    end

    assign sda_bit   = sda_bit_q;
    assign scl_rise  = scl_rise_q;
    assign scl_fall  = scl_fall_q;
    assign start_det = start_q;
    assign stop_det  = stop_q;
endmodule

// File: rtl/i2c_eeprom_target.sv
// rtl/i2c_eeprom_target.sv - I2C target emulating a 24xx EEPROM with 16-bit word addressing
// Build option EEPROM_WRITE_BUSY_EN: write-cycle timer drives busy and address polls are NACKed while busy.
module i2c_eeprom_target
    import eeprom_pkg::*;
#(
    parameter logic [6:0] SLA7       = SLA7_DEFAULT,
    parameter int         ADDR_W     = 10,
    parameter int         PAGE_BYTES = 32,
    parameter int         WR_CYCLES  = 5000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                scl_in,
    input  logic                sda_in,
    output logic                sda_oe,
    input  logic                wp,
    output logic                busy,
    output logic [ADDR16_W-1:0] ptr
);
    localparam int                  DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR16_W-1:0] ADDR_MASK = ADDR16_W'((32'd1 << ADDR_W) - 32'd1);
    localparam logic [ADDR16_W-1:0] PAGE_MASK = ADDR16_W'(PAGE_BYTES - 1);

    logic sda_bit, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sync u_bus_sync (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda_bit   (sda_bit),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    i2c_state_e          state_q, state_d;
    logic [3:0]          bit_cnt_q, bit_cnt_d;
    logic [7:0]          shreg_q, shreg_d;
    logic [7:0]          ah_q, ah_d;
    logic [7:0]          rd_q, rd_d;
    logic [ADDR16_W-1:0] ptr_q, ptr_d;
    logic                sda_oe_q, sda_oe_d;
    logic                stored_q, stored_d;
    logic                wr_ok_q, wr_ok_d;
    logic                mem_we;
    logic                busy_w;

    logic [7:0] mem [DEPTH];

    logic [7:0]          byte_in;
    logic [7:0]          rd_fetch;
    logic [ADDR16_W-1:0] ptr_inc;
    logic [ADDR16_W-1:0] page_inc;
    logic                byte_done;

    assign byte_in   = {shreg_q[6:0], sda_bit};
    assign rd_fetch  = mem[ptr_q[ADDR_W-1:0]];
    assign ptr_inc   = ((ptr_q & ADDR_MASK) == ADDR_MASK) ? '0 : ptr_q + 16'd1;
    assign page_inc  = (ptr_q & ~PAGE_MASK) | ((ptr_q + 16'd1) & PAGE_MASK);
    assign byte_done = (bit_cnt_q == 4'd8);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        ah_d      = ah_q;
        rd_d      = rd_q;
        ptr_d     = ptr_q;
        sda_oe_d  = sda_oe_q;
        stored_d  = stored_q;
        wr_ok_d   = wr_ok_q;
        mem_we    = 1'b0;
        if (stop_det) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            stored_d  = 1'b0;
        end else if (start_det) begin
            state_d   = ST_DEV;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else if (scl_rise) begin
            case (state_q)
                ST_DEV, ST_AH, ST_AL, ST_WDATA, ST_RACK: begin
                    if (!bit_cnt_q[3]) begin
                        shreg_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        // data byte is committed on its eighth bit so the ACK decision is already known
                        if (state_q == ST_WDATA && bit_cnt_q == 4'd7) begin
                            wr_ok_d = !wp;
                            if (!wp) begin
                                mem_we   = 1'b1;
                                ptr_d    = page_inc;
                                stored_d = 1'b1;
                            end
                        end
                    end
                end
                ST_RDATA: if (!bit_cnt_q[3]) bit_cnt_d = bit_cnt_q + 4'd1;
                default: ;
            endcase
        end else if (scl_fall) begin
            case (state_q)
                ST_DEV: if (byte_done) begin
                    bit_cnt_d = '0;
                    if (shreg_q[7:1] == SLA7 && !busy_w) begin
                        state_d  = ST_ACK_DEV;
                        sda_oe_d = 1'b1;
                    end else begin
                        state_d  = ST_IGNORE;
                    end
                end
                ST_ACK_DEV: begin
                    sda_oe_d = 1'b0;
                    if (shreg_q[0]) begin
                        state_d  = ST_RDATA;
                        rd_d     = rd_fetch;
                        sda_oe_d = ~rd_fetch[7];
                        ptr_d    = ptr_inc;
                    end else begin
                        state_d  = ST_AH;
                    end
                end
                ST_AH: if (byte_done) begin
                    bit_cnt_d = '0;
                    ah_d      = shreg_q;
                    state_d   = ST_ACK_AH;
                    sda_oe_d  = 1'b1;
                end
                ST_ACK_AH: begin
                    sda_oe_d = 1'b0;
                    state_d  = ST_AL;
                end
                ST_AL: if (byte_done) begin
                    bit_cnt_d = '0;
                    ptr_d     = {ah_q, shreg_q};
                    state_d   = ST_ACK_AL;
                    sda_oe_d  = 1'b1;
                end
                ST_ACK_AL, ST_ACK_W: begin
                    sda_oe_d = 1'b0;
                    state_d  = ST_WDATA;
                end
                ST_WDATA: if (byte_done) begin
                    bit_cnt_d = '0;
                    if (wr_ok_q) begin
                        state_d  = ST_ACK_W;
                        sda_oe_d = 1'b1;
                    end else begin
                        state_d  = ST_IGNORE;
                    end
                end
                ST_RDATA: begin
                    if (byte_done) begin
                        bit_cnt_d = '0;
                        sda_oe_d  = 1'b0;
                        state_d   = ST_RACK;
                    end else if (bit_cnt_q != 4'd0) begin
                        sda_oe_d = ~rd_q[3'd7 - bit_cnt_q[2:0]];
                    end
                end
                ST_RACK: if (bit_cnt_q == 4'd1) begin
                    bit_cnt_d = '0;
                    if (shreg_q[0] == I2C_ACK) begin
                        state_d  = ST_RDATA;
                        rd_d     = rd_fetch;
                        sda_oe_d = ~rd_fetch[7];
                        ptr_d    = ptr_inc;
                    end else begin
                        state_d  = ST_IGNORE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            ah_q      <= '0;
            rd_q      <= '0;
            ptr_q     <= '0;
            sda_oe_q  <= 1'b0;
            stored_q  <= 1'b0;
            wr_ok_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            ah_q      <= ah_d;
            rd_q      <= rd_d;
            ptr_q     <= ptr_d;
            sda_oe_q  <= sda_oe_d;
            stored_q  <= stored_d;
            wr_ok_q   <= wr_ok_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[ptr_q[ADDR_W-1:0]] <= byte_in;
    end

`ifdef EEPROM_WRITE_BUSY_EN
    localparam int CNT_W = $clog2(WR_CYCLES + 1);

    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        if (wr_cnt_q != '0) wr_cnt_d = wr_cnt_q - 1'b1;
        if (stop_det && stored_q) wr_cnt_d = CNT_W'(WR_CYCLES);
    end

    always_ff @(posedge clk) begin
        if (reset) wr_cnt_q <= '0;
        else       wr_cnt_q <= wr_cnt_d;
    end

    assign busy_w = (wr_cnt_q != '0);
`else
    logic unused_wr_cycle;
    assign unused_wr_cycle = stored_q & (WR_CYCLES > 0);
    assign busy_w          = 1'b0;
`endif

    assign busy   = busy_w;
    assign sda_oe = sda_oe_q;
    assign ptr    = ptr_q;
endmodule

// File: tb/tb_i2c_eeprom_target.sv
// tb/tb_i2c_eeprom_target.sv - scoreboard bench driving raw SCL/SDA into the EEPROM target
module tb_i2c_eeprom_target;
`ifdef EEPROM_WRITE_BUSY_EN
    localparam int BUSY_EXP = 5000;
    localparam int WR_WAIT  = 5100;
`else
    localparam int BUSY_EXP = 0;
    localparam int WR_WAIT  = 20;
`endif

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic        wp    = 1'b0;
    logic        sda_oe;
    logic        busy;
    logic [15:0] ptr;
    logic        sda_line;

    assign sda_line = sda_m & ~sda_oe;

    i2c_eeprom_target #(
        .SLA7       (7'h50),
        .ADDR_W     (10),
        .PAGE_BYTES (32),
        .WR_CYCLES  (5000)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .scl_in (scl_m),
        .sda_in (sda_line),
        .sda_oe (sda_oe),
        .wp     (wp),
        .busy   (busy),
        .ptr    (ptr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int stop_cyc = 0;
    int bcnt = 0;
    bit mon_en = 1'b0;
    int oe_hits = 0;

    always @(negedge clk) if (mon_en && sda_oe) oe_hits++;

    string       sb_tag[$];
    logic [31:0] sb_exp[$];

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: cycles=%0d limit=95000", cyc);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] v);
        sb_tag.push_back(tag);
        sb_exp.push_back(v);
    endtask

    task automatic sb_pop(input logic [31:0] got);
        string tag;
        logic [31:0] exp;
        tag = sb_tag.pop_front();
        exp = sb_exp.pop_front();
        chk(tag, got, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tx_bit(input bit b);
        wait_clk(2); sda_m = b;
        wait_clk(8); scl_m = 1'b1;
        wait_clk(10); scl_m = 1'b0;
    endtask

    task automatic rx_bit(output bit b);
        wait_clk(2); sda_m = 1'b1;
        wait_clk(8); scl_m = 1'b1;
        wait_clk(5); b = sda_line;
        wait_clk(5); scl_m = 1'b0;
    endtask

    task automatic i2c_start();
        wait_clk(2); sda_m = 1'b1;
        wait_clk(6); scl_m = 1'b1;
        wait_clk(10); sda_m = 1'b0;
        wait_clk(10); scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clk(2); sda_m = 1'b0;
        wait_clk(6); scl_m = 1'b1;
        wait_clk(10); sda_m = 1'b1;
        wait_clk(10);
    endtask

    // expected value is the SDA level seen on the ACK clock: 0 = ACK, 1 = NACK
    task automatic wr_byte(input string tag, input logic [7:0] b, input bit exp_ack);
        bit a;
        sb_push(tag, {31'd0, ~exp_ack});
        for (int i = 7; i >= 0; i--) tx_bit(b[i]);
        rx_bit(a);
        sb_pop({31'd0, a});
    endtask

    task automatic rd_byte(input string tag, input logic [7:0] exp, input bit master_ack);
        bit   b;
        logic [7:0] v;
        sb_push(tag, {24'd0, exp});
        for (int i = 7; i >= 0; i--) begin
            rx_bit(b);
            v[i] = b;
        end
        sb_pop({24'd0, v});
        tx_bit(!master_ack);
    endtask

    task automatic set_addr(input string tag, input logic [15:0] addr);
        i2c_start();
        wr_byte({tag, "_dev"}, 8'hA0, 1'b1);
        wr_byte({tag, "_ah"}, addr[15:8], 1'b1);
        wr_byte({tag, "_al"}, addr[7:0], 1'b1);
    endtask

    task automatic write_seq(input string tag, input logic [15:0] addr, input logic [31:0] data, input int n);
        set_addr(tag, addr);
        for (int i = 0; i < n; i++) wr_byte({tag, "_data"}, data[31-8*i -: 8], 1'b1);
        i2c_stop();
    endtask

    task automatic read_seq(input string tag, input logic [15:0] addr, input int n, input logic [31:0] exp);
        set_addr(tag, addr);
        i2c_start();
        wr_byte({tag, "_rdev"}, 8'hA1, 1'b1);
        for (int i = 0; i < n; i++) rd_byte({tag, "_rd"}, exp[31-8*i -: 8], i != n - 1);
        i2c_stop();
    endtask

    task automatic poll(input bit exp_ack);
        i2c_start();
        wr_byte(exp_ack ? "poll_ack" : "poll_nack", 8'hA0, exp_ack);
        i2c_stop();
    endtask

    initial begin
        wait_clk(5);
        chk("reset_sda_oe", {31'd0, sda_oe}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_ptr", {16'd0, ptr}, 32'd0);
        reset = 1'b0;
        wait_clk(10);

        fork
            begin
                for (int bi = 0; bi < 7500; bi++) begin
                    @(negedge clk);
                    if (busy) bcnt++;
                end
            end
            begin
                write_seq("wr", 16'h0010, 32'hDEADBEEF, 4);
                stop_cyc = cyc;
`ifdef EEPROM_WRITE_BUSY_EN
                begin : polls
                    int  rel;
                    int  nacks;
                    bit  done;
                    nacks = 0;
                    done  = 1'b0;
                    for (int k = 0; k < 40 && !done; k++) begin
                        rel = cyc - stop_cyc;
                        if (rel + 260 < 4950) begin
                            poll(1'b0);
                            nacks++;
                        end else if (rel > 5005) begin
                            poll(1'b1);
                            done = 1'b1;
                        end else begin
                            wait_clk(5006 - rel);
                        end
                    end
                    chk("poll_nacks_seen", {31'd0, nacks > 0}, 32'd1);
                    chk("poll_acked", {31'd0, done}, 32'd1);
                end
`else
                poll(1'b1);
`endif
            end
        join
        chk("busy_len", bcnt, BUSY_EXP);

        read_seq("rr", 16'h0010, 4, 32'hDEADBEEF);
        chk("rr_ptr", {16'd0, ptr}, 32'h0014);

        write_seq("pw", 16'h001F, 32'h11223300, 3);
        wait_clk(WR_WAIT);
        read_seq("pw1f", 16'h001F, 1, 32'h11000000);
        read_seq("pw00", 16'h0000, 2, 32'h22330000);

        write_seq("w3ff", 16'h03FF, 32'h5A000000, 1);
        wait_clk(WR_WAIT);
        read_seq("sq", 16'h03FF, 2, 32'h5A220000);
        chk("sq_ptr", {16'd0, ptr}, 32'h0001);

        mon_en = 1'b1;
        i2c_start();
        wr_byte("sla51", 8'hA2, 1'b0);
        wr_byte("sla51_ign", 8'h00, 1'b0);
        i2c_stop();
        mon_en = 1'b0;
        chk("sla51_oe", oe_hits, 32'd0);

        wp = 1'b1;
        set_addr("wp", 16'h0010);
        wr_byte("wp_data", 8'h77, 1'b0);
        i2c_stop();
        wp = 1'b0;
        wait_clk(10);
        chk("wp_busy", {31'd0, busy}, 32'd0);
        read_seq("wp_rd", 16'h0010, 1, 32'hDE000000);

        i2c_start();
        wr_byte("al_dev", 8'hA0, 1'b1);
        wr_byte("al_ah", 8'h00, 1'b1);
        tx_bit(1'b0); tx_bit(1'b0); tx_bit(1'b0); tx_bit(1'b1);
        i2c_stop();
        chk("al_stop_oe", {31'd0, sda_oe}, 32'd0);
        read_seq("al_rec", 16'h0011, 1, 32'hAD000000);

        begin : rst_rd
            bit b;
            set_addr("rst", 16'h0012);
            i2c_start();
            wr_byte("rst_rdev", 8'hA1, 1'b1);
            rx_bit(b);
            wait_clk(6);
            chk("rst_drive", {31'd0, sda_oe}, 32'd1);
            reset = 1'b1;
            wait_clk(1);
            reset = 1'b0;
            wait_clk(3);
            chk("rst_release", {31'd0, sda_oe}, 32'd0);
            chk("rst_ptr", {16'd0, ptr}, 32'd0);
            scl_m = 1'b1;
            wait_clk(10);
        end
        read_seq("rst_rec", 16'h0013, 1, 32'hEF000000);

        chk("sb_drained", sb_exp.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/i2c_eeprom_target.md
# i2c_eeprom_target

Synthesizable I2C target that emulates a 24xx-style serial EEPROM with 16-bit word addressing. It is the bus-side responder to the team's EEPROM controller and byte-level I2C master: in simulation and on-board loopback it answers device-address polling, random and sequential reads, and page writes. It decodes raw SCL/SDA and drives SDA open-drain.

## Interface
Parameters:
- SLA7, 7'h50, 7-bit device address matched on the bus
- ADDR_W, 10, implemented memory address bits; depth 2^ADDR_W bytes; upper pointer bits ignored
- PAGE_BYTES, 32, write page size in bytes, power of two, not larger than 2^ADDR_W
- WR_CYCLES, 5000, internal write-cycle duration in clk cycles

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- scl_in  in  1  raw SCL level (asynchronous)
- sda_in  in  1  raw SDA level (asynchronous)
- sda_oe  out  1  1 = pull SDA low; 0 = release
- wp  in  1  write protect; 1 = data bytes NACKed and not stored
- busy  out  1  internal write cycle in progress
- ptr  out  16  current address pointer (debug)

## Operation
- SCL/SDA pass through 2-flop synchronizers. START = SDA falls while SCL high; STOP = SDA rises while SCL high. Data bits are sampled on SCL rise, MSB first. sda_oe changes only after an SCL fall.
- States: IDLE, DEV, ACK_DEV, AH, ACK_AH, AL, ACK_AL, WDATA, ACK_W, RDATA, RACK, IGNORE.
- START or repeated START in any state goes to DEV with bit count 0. STOP in any state goes to IDLE and releases SDA.
- DEV: after 8 bits, compare [7:1] with SLA7.
  - Mismatch goes to IGNORE with no ACK.
  - Match with R/W=0 goes to ACK_DEV, then AH.
  - Match with R/W=1 goes to ACK_DEV, then RDATA.
- AH/AL: each byte is ACKed. After AL, ptr = {AH, AL}.
- WDATA: each byte is ACKed.
  - When wp=0: mem[ptr] is written and the page offset increments, wrapping within the page. ptr[15:log2 PAGE_BYTES] does not change.
  - When wp=1: the byte is NACKed and nothing is written. The next state is IGNORE.
- RDATA: output mem[ptr] on SDA, then increment ptr, wrapping at 2^ADDR_W back to 0.
  - RACK: master ACK returns to RDATA for the next byte.
  - Master NACK goes to IGNORE.
- Write cycle: a STOP that follows at least one stored data byte loads the counter with WR_CYCLES and sets busy for exactly WR_CYCLES clk.
- Reset values: sda_oe=0, busy=0, ptr=0, state IDLE, counters 0. Memory contents are not reset.
- A reset asserted mid-transfer releases SDA on the next clk. The bus then resyncs on the next START.

## Timing
- Synchronizer plus edge detect adds 3 clk of latency from a pin change to the detected event.
- Bus requirements: SCL high and low phases ≥ 8 clk each. SDA setup before the SCL rise ≥ 4 clk.
- ACK drive: sda_oe rises within 1 clk of the detected SCL fall that ends bit 8. It falls within 1 clk of the detected SCL fall that ends bit 9.
- Read data: each bit is placed on sda_oe (~bit) within 1 clk of the detected preceding SCL fall. During RACK, SDA is released.
- A memory write occurs on the clk in which bit 8 of a data byte is sampled. Read data is fetched when entering RDATA, so there are no bus stalls. Clock stretching is not used.
- If START and STOP are detected in the same clk (glitch), STOP wins.

## Configuration
- EEPROM_WRITE_BUSY_EN defined: while busy=1, a matching device address is NACKed (the bus then goes to IGNORE). This supports master ACK polling.
- EEPROM_WRITE_BUSY_EN undefined: busy is tied to 0. No counter logic is generated, and the device always ACKs a matching address.

## Structure
- Shared package eeprom_pkg holds:
  - the state enum
  - the SLA7 default 7'h50
  - the ACK/NACK constants
  - the 16-bit address width
- Sub-module i2c_bus_sync contains the synchronizers, the SCL rise/fall strobes, and the START/STOP strobes. It is shareable with other I2C targets.
- The top level holds the FSM, the byte shift register, the pointer, the memory array, and the write-cycle counter.

## Test plan
- Write of 16'h0010 with 0xDE 0xAD 0xBE 0xEF, then STOP. Required response:
  - all 7 bytes are ACKed
  - mem[0x10..0x13] hold those values
  - busy is high for exactly 5000 clk
- With the macro on: address polling right after the STOP is NACKed until busy falls, and the first poll after that is ACKed.
- Random read of 0x0010 (4 bytes, last one NACKed) returns 0xDEADBEEF, and ptr ends at 0x0014.
- Page wrap: writing 3 bytes at 0x001F stores them at 0x1F, 0x00, and 0x01. A sequential read from 0x3FF returns mem[0x3FF] followed by mem[0x000].
- Device address 7'h51 is NACKed with SDA released through STOP. A byte written with wp=1 is NACKed and memory is unchanged.
- STOP in the middle of AL, and a reset during RDATA: SDA is released within 4 clk, and the next full transaction succeeds.
